// File: rtl/rst_seq_ctrl.sv
// ============================================================================
// Module : rst_seq_ctrl
// Brief  : Board reset/clock bring-up sequencer: PLL reset, lock wait with
//          timeout/retry, ordered peripheral then CPU reset release.
//          Optional watchdog built when RST_SEQ_WDT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq_ctrl #(
    parameter int PLL_RST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT    = 65535,
    parameter int PERIPH_DELAY    = 255,
    parameter int CPU_DELAY       = 255,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int WDT_CYCLES      = 1048575,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       btn,
    output logic       pll_rst,
    output logic       periph_rst,
    output logic       cpu_rst,
    output logic [2:0] state_o,
    output logic [3:0] fail_cnt,
    input  logic       wdt_kick,
    output logic       wdt_fired
);

    localparam logic [2:0] c_st_pll_rst     = 3'd0;
    localparam logic [2:0] c_st_wait_lock   = 3'd1;
    localparam logic [2:0] c_st_periph_wait = 3'd2;
    localparam logic [2:0] c_st_cpu_wait    = 3'd3;
    localparam logic [2:0] c_st_run         = 3'd4;

    localparam logic [CNT_W-1:0] c_pll_last  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_lock_last = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_per_last  = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [CNT_W-1:0] c_cpu_last  = CNT_W'(CPU_DELAY - 1);
    localparam logic [CNT_W-1:0] c_db_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_wdt_last  = CNT_W'(WDT_CYCLES - 1);

    logic             r_lock_meta, r_lock_s;
    logic             r_btn_meta, r_btn_s;
    logic             r_btn_db;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] w_db_inc;
    logic [2:0]       r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hold, w_timeout, w_wdt_expire, w_wdt_take;
    logic             r_pll_rst, r_periph_rst, r_cpu_rst, r_wdt_fired;
    logic             w_pll_rst_nx, w_periph_rst_nx, w_cpu_rst_nx;
    logic [3:0]       r_fail_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_btn_meta  <= 1'b0;
            r_btn_s     <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
            r_btn_meta  <= btn;
            r_btn_s     <= r_btn_meta;
        end
    end

    // Counter runs only while the synchronised button disagrees with the accepted level
    assign w_db_inc = r_db_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_cnt <= '0;
            r_btn_db <= 1'b0;
        end else if (r_btn_s == r_btn_db) begin
            r_db_cnt <= '0;
        end else if (w_db_inc >= c_db_last) begin
            r_db_cnt <= '0;
            r_btn_db <= r_btn_s;
        end else begin
            r_db_cnt <= w_db_inc;
        end
    end

`ifdef RST_SEQ_WDT_EN
    logic [CNT_W-1:0] r_wdt_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdt_cnt <= '0;
        end else if (r_state == c_st_run && w_next_state == c_st_run && !wdt_kick) begin
            r_wdt_cnt <= r_wdt_cnt + CNT_W'(1);
        end else begin
            r_wdt_cnt <= '0;
        end
    end

    assign w_wdt_expire = (r_state == c_st_run) && !wdt_kick && (r_wdt_cnt == c_wdt_last);
`else
    logic w_unused_wdt;
    assign w_unused_wdt = wdt_kick | (|c_wdt_last);
    assign w_wdt_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_st_pll_rst;
            r_cnt        <= '0;
            r_pll_rst    <= 1'b1;
            r_periph_rst <= 1'b1;
            r_cpu_rst    <= 1'b1;
            r_wdt_fired  <= 1'b0;
            r_fail_cnt   <= 4'd0;
        end else begin
            r_state      <= w_next_state;
            r_pll_rst    <= w_pll_rst_nx;
            r_periph_rst <= w_periph_rst_nx;
            r_cpu_rst    <= w_cpu_rst_nx;
            r_wdt_fired  <= w_wdt_take;
            if (w_next_state != r_state || w_hold) begin
                r_cnt <= '0;
            end else if (r_state != c_st_run) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_timeout && r_fail_cnt != 4'hF) begin
                r_fail_cnt <= r_fail_cnt + 4'd1;
            end
        end
    end

    // Lock loss beats the button, which beats any counter expiry
    always_comb begin
        w_next_state = r_state;
        w_hold       = 1'b0;
        w_timeout    = 1'b0;
        w_wdt_take   = 1'b0;
        case (r_state)
            c_st_pll_rst: begin
                if (r_cnt == c_pll_last) w_next_state = c_st_wait_lock;
            end
            c_st_wait_lock: begin
                if (r_lock_s) begin
                    w_next_state = c_st_periph_wait;
                end else if (r_cnt == c_lock_last) begin
                    w_next_state = c_st_pll_rst;
                    w_timeout    = 1'b1;
                end
            end
            c_st_periph_wait, c_st_cpu_wait, c_st_run: begin
                if (!r_lock_s) begin
                    w_next_state = c_st_pll_rst;
                end else if (r_btn_db) begin
                    w_next_state = c_st_periph_wait;
                    w_hold       = 1'b1;
                end else if (r_state == c_st_periph_wait) begin
                    if (r_cnt == c_per_last) w_next_state = c_st_cpu_wait;
                end else if (r_state == c_st_cpu_wait) begin
                    if (r_cnt == c_cpu_last) w_next_state = c_st_run;
                end else if (w_wdt_expire) begin
                    w_next_state = c_st_cpu_wait;
                    w_wdt_take   = 1'b1;
                end
            end
            default: w_next_state = c_st_pll_rst;
        endcase
    end

    always_comb begin
        w_pll_rst_nx    = 1'b1;
        w_periph_rst_nx = 1'b1;
        w_cpu_rst_nx    = 1'b1;
        case (w_next_state)
            c_st_wait_lock, c_st_periph_wait: w_pll_rst_nx = 1'b0;
            c_st_cpu_wait: begin
                w_pll_rst_nx    = 1'b0;
                w_periph_rst_nx = 1'b0;
            end
            c_st_run: begin
                w_pll_rst_nx    = 1'b0;
                w_periph_rst_nx = 1'b0;
                w_cpu_rst_nx    = 1'b0;
            end
            default: ;
        endcase
    end

    assign pll_rst    = r_pll_rst;
    assign periph_rst = r_periph_rst;
    assign cpu_rst    = r_cpu_rst;
    assign state_o    = r_state;
    assign fail_cnt   = r_fail_cnt;
    assign wdt_fired  = r_wdt_fired;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
// ============================================================================
// Module : tb_rst_seq_ctrl
// Brief  : Directed bench for rst_seq_ctrl with hand-computed cycle timing.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       btn = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       pll_rst, periph_rst, cpu_rst, wdt_fired;
    logic [2:0] state_o;
    logic [3:0] fail_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .PERIPH_DELAY   (8),
        .CPU_DELAY      (6),
        .DEBOUNCE_CYCLES(5),
        .WDT_CYCLES     (30),
        .CNT_W          (20)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pll_locked(pll_locked),
        .btn       (btn),
        .pll_rst   (pll_rst),
        .periph_rst(periph_rst),
        .cpu_rst   (cpu_rst),
        .state_o   (state_o),
        .fail_cnt  (fail_cnt),
        .wdt_kick  (wdt_kick),
        .wdt_fired (wdt_fired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_rsts(input string tag, input logic p, input logic q, input logic c);
        check({tag, "_pll"},    32'(pll_rst),    32'(p));
        check({tag, "_periph"}, 32'(periph_rst), 32'(q));
        check({tag, "_cpu"},    32'(cpu_rst),    32'(c));
    endtask

    initial begin
        // Reset state while reset_n is held low
        pll_locked = 1'b1;
        tick(2);
        check_rsts("rst", 1'b1, 1'b1, 1'b1);
        check("rst_state", 32'(state_o), 0);
        check("rst_fail", 32'(fail_cnt), 0);
        check("rst_wdt", 32'(wdt_fired), 0);

        // Cold start with lock present
        reset_n = 1'b1;
        tick(3);
        check("cold_e3_state", 32'(state_o), 0);
        check("cold_e3_pll", 32'(pll_rst), 1);
        tick(1);
        check("cold_e4_state", 32'(state_o), 1);
        check("cold_e4_pll", 32'(pll_rst), 0);
        tick(1);
        check("cold_e5_state", 32'(state_o), 2);
        tick(7);
        check("cold_e12_periph", 32'(periph_rst), 1);
        tick(1);
        check_rsts("cold_e13", 1'b0, 1'b0, 1'b1);
        check("cold_e13_state", 32'(state_o), 3);
        tick(5);
        check("cold_e18_cpu", 32'(cpu_rst), 1);
        tick(1);
        check_rsts("cold_e19", 1'b0, 1'b0, 1'b0);
        check("cold_e19_state", 32'(state_o), 4);

        // One-cycle lock drop in RUN
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        check("drop_a1_state", 32'(state_o), 4);
        tick(1);
        check("drop_a2_state", 32'(state_o), 0);
        check_rsts("drop_a2", 1'b1, 1'b1, 1'b1);
        tick(4);
        check("drop_a6_state", 32'(state_o), 1);
        tick(1);
        check("drop_a7_state", 32'(state_o), 2);
        tick(8);
        check("drop_a15_state", 32'(state_o), 3);
        check("drop_a15_periph", 32'(periph_rst), 0);
        tick(6);
        check("drop_a21_state", 32'(state_o), 4);
        check("drop_a21_cpu", 32'(cpu_rst), 0);

        // Short button glitch is rejected
        btn = 1'b1;
        tick(3);
        btn = 1'b0;
        tick(10);
        check("glitch_state", 32'(state_o), 4);
        check_rsts("glitch", 1'b0, 1'b0, 1'b0);

        // Long button press
        btn = 1'b1;
        tick(6);
        check("btn_b6_state", 32'(state_o), 4);
        tick(1);
        check("btn_b7_state", 32'(state_o), 2);
        check_rsts("btn_b7", 1'b0, 1'b1, 1'b1);
        tick(5);
        btn = 1'b0;
        tick(13);
        check("btn_b25_state", 32'(state_o), 2);
        check("btn_b25_periph", 32'(periph_rst), 1);
        tick(1);
        check("btn_b26_state", 32'(state_o), 3);
        check_rsts("btn_b26", 1'b0, 1'b0, 1'b1);
        tick(6);
        check("btn_b32_state", 32'(state_o), 4);
        check("btn_b32_cpu", 32'(cpu_rst), 0);

`ifdef RST_SEQ_WDT_EN
        // Unserviced watchdog
        tick(29);
        check("wdt_e29_state", 32'(state_o), 4);
        check("wdt_e29_fired", 32'(wdt_fired), 0);
        tick(1);
        check("wdt_e30_state", 32'(state_o), 3);
        check("wdt_e30_fired", 32'(wdt_fired), 1);
        check_rsts("wdt_e30", 1'b0, 1'b0, 1'b1);
        tick(1);
        check("wdt_e31_fired", 32'(wdt_fired), 0);
        tick(4);
        check("wdt_e35_state", 32'(state_o), 3);
        check("wdt_e35_cpu", 32'(cpu_rst), 1);
        tick(1);
        check("wdt_e36_state", 32'(state_o), 4);
        check("wdt_e36_cpu", 32'(cpu_rst), 0);
        // Serviced every 10 cycles
        for (int i = 0; i < 6; i++) begin
            tick(9);
            wdt_kick = 1'b1;
            tick(1);
            wdt_kick = 1'b0;
            check("kick_state", 32'(state_o), 4);
            check("kick_fired", 32'(wdt_fired), 0);
        end
`else
        wdt_kick = 1'b0;
        tick(40);
        check("nowdt_state", 32'(state_o), 4);
        check("nowdt_fired", 32'(wdt_fired), 0);
`endif

        // No lock: timeout, retry and saturating fail count
        pll_locked = 1'b0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(23);
        check("nolock_e23_state", 32'(state_o), 1);
        check("nolock_e23_fail", 32'(fail_cnt), 0);
        tick(1);
        check("nolock_e24_state", 32'(state_o), 0);
        check("nolock_e24_fail", 32'(fail_cnt), 1);
        check_rsts("nolock_e24", 1'b1, 1'b1, 1'b1);
        tick(4);
        check("nolock_e28_state", 32'(state_o), 1);
        check("nolock_e28_pll", 32'(pll_rst), 0);
        tick(20);
        check("nolock_e48_fail", 32'(fail_cnt), 2);
        check("nolock_e48_state", 32'(state_o), 0);
        tick(352);
        check("nolock_e400_fail", 32'(fail_cnt), 15);
        check("nolock_e400_state", 32'(state_o), 1);
        check_rsts("nolock_e400", 1'b0, 1'b1, 1'b1);

        // Lock arrives late, then reset_n asserted in CPU_WAIT
        pll_locked = 1'b1;
        tick(13);
        check("late_state", 32'(state_o), 3);
        check("late_fail", 32'(fail_cnt), 15);
        #2;
        reset_n = 1'b0;
        #1;
        check_rsts("async", 1'b1, 1'b1, 1'b1);
        check("async_state", 32'(state_o), 0);
        check("async_fail", 32'(fail_cnt), 0);
        check("async_wdt", 32'(wdt_fired), 0);
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
